// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

  localparam logic [31:0] SALIDA_ADDR_DEF = 32'h0000_00FC;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; on a tie the requester that did not
// win last time is chosen.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_winner_i,
  output req_id_t    winner_o
);

  always_comb begin
    winner_o = ID_M0;
    case (req_i)
      2'b10:   winner_o = ID_M1;
      2'b11:   winner_o = ~last_winner_i;
      default: winner_o = ID_M0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous data-memory port between a CPU (m0) and a second
// requester (m1). Define MEM_BUS_SALIDA_EN to map the salida output bit at SALIDA_ADDR.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] SALIDA_ADDR = ADDR_W'(SALIDA_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              salida
);

  state_t            state_q, state_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_q, last_d;
  req_id_t           winner;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              sal_hit;
  logic              rd_sal_q;

  rr_arb2 u_rr_arb2 (
    .req_i         ({m1_req, m0_req}),
    .last_winner_i (last_q),
    .winner_o      (winner)
  );

  // Requesters hold their fields until gnt, so the owner's inputs are used directly.
  assign own_we    = (owner_q == ID_M1) ? m1_we    : m0_we;
  assign own_addr  = (owner_q == ID_M1) ? m1_addr  : m0_addr;
  assign own_wdata = (owner_q == ID_M1) ? m1_wdata : m0_wdata;

`ifdef MEM_BUS_SALIDA_EN
  logic salida_q, salida_d;
  logic rd_sal_d;

  assign sal_hit = (own_addr == SALIDA_ADDR);
  assign salida  = salida_q;

  always_comb begin
    salida_d = salida_q;
    rd_sal_d = rd_sal_q;
    if (state_q == ACCESS) begin
      rd_sal_d = sal_hit & ~own_we;
      if (sal_hit && own_we) salida_d = own_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      salida_q <= 1'b0;
      rd_sal_q <= 1'b0;
    end else begin
      salida_q <= salida_d;
      rd_sal_q <= rd_sal_d;
    end
  end
`else
  logic unused_salida_addr;

  assign sal_hit            = 1'b0;
  assign rd_sal_q           = 1'b0;
  assign salida             = 1'b0;
  assign unused_salida_addr = ^SALIDA_ADDR;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= ID_M0;
      last_q  <= ID_M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    resp_data = rd_sal_q ? DATA_W'(salida) : mem_rdata;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          owner_d = winner;
          last_d  = winner;
        end
      end
      ACCESS: begin
        mem_addr  = own_addr;
        mem_wdata = own_wdata;
        mem_we    = own_we & ~sal_hit;
        if (owner_q == ID_M1) m1_gnt = 1'b1;
        else                  m0_gnt = 1'b1;
        state_d = own_we ? IDLE : RESP;
      end
      RESP: begin
        if (owner_q == ID_M1) begin
          m1_rvalid = 1'b1;
          m1_rdata  = resp_data;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = resp_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
